bias_ram_loader: RTL and testbench

//  Write side of the bias RAM. Takes packed bias words from the DMA stream, unpacks them

---
 rtl/bias_ram_loader_pkg.sv | 26 ++
 rtl/bias_lane_unpack.sv | 77 +++++++
 rtl/bias_ram_loader.sv | 158 +++++++++++++++
 tb/tb_bias_ram_loader.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_ram_loader_pkg.sv
// Shared definitions for the bias RAM loader: FSM encodings,
// default widths and the lane-count helpers.
package bias_ram_loader_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_BIAS_WIDTH = 16;
    localparam int DEF_IN_WIDTH   = 32;

    // bias entries carried by one stream word
    function automatic int lanes_of(input int in_w, input int bias_w);
        return in_w / bias_w;
    endfunction

    // stream words needed for n entries (ceiling division)
    function automatic logic [7:0] words_for(input logic [7:0] n,
                                             input int         lanes);
        int t;
        t = (int'(n) + lanes - 1) / lanes;
        return t[7:0];
    endfunction

endpackage

// File: rtl/bias_lane_unpack.sv
// Lane unpacker: lane 0 of a new word bypasses straight to the
// write port, the remaining lanes wait in the hold register.
module bias_lane_unpack
    import bias_ram_loader_pkg::*;
#(
    parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
    parameter int IN_WIDTH   = DEF_IN_WIDTH
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_clear,
    input  logic                  i_xfer,
    input  logic                  i_take,
    input  logic                  i_drop,
    input  logic [IN_WIDTH-1:0]   i_data,
    output logic                  o_hold_vld,
    output logic                  o_hold_last,
    output logic                  o_src_vld,
    output logic [BIAS_WIDTH-1:0] o_src_dat
);

    localparam int LANES = lanes_of(IN_WIDTH, BIAS_WIDTH);
    localparam int IW    = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [IW-1:0] LAST_IDX   = IW'(LANES - 1);
    localparam logic [IW-1:0] FIRST_NEXT = (LANES > 1) ? IW'(1) : '0;
    localparam logic          MULTI      = (LANES > 1);

    logic [IN_WIDTH-1:0]   r_hold;
    logic [IW-1:0]         r_idx;
    logic                  r_vld;
    logic                  w_at_last;
    logic [BIAS_WIDTH-1:0] w_lane;

    assign w_at_last   = (r_idx == LAST_IDX);
    assign o_hold_vld  = r_vld;
    assign o_hold_last = r_vld && w_at_last;
    assign o_src_vld   = r_vld || i_xfer;
    assign o_src_dat   = r_vld ? w_lane : i_data[BIAS_WIDTH-1:0];

    // select the pending lane of the held word
    always_comb begin
        w_lane = '0;
        for (int i = 0; i < LANES; i++) begin
            if (r_idx == IW'(i)) begin
                w_lane = r_hold[i*BIAS_WIDTH +: BIAS_WIDTH];
            end
        end
    end

    // advance lane index, reload on transfer, drop the tail lanes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hold <= '0;
            r_idx  <= '0;
            r_vld  <= 1'b0;
        end else if (i_clear) begin
            r_idx  <= '0;
            r_vld  <= 1'b0;
        end else if (i_take) begin
            if (i_drop) begin
                r_idx <= '0;
                r_vld <= 1'b0;
            end else if (r_vld && !w_at_last) begin
                r_idx <= r_idx + IW'(1);
            end else if (i_xfer) begin
                r_hold <= i_data;
                r_idx  <= r_vld ? '0 : FIRST_NEXT;
                r_vld  <= r_vld || MULTI;
            end else begin
                r_idx <= '0;
                r_vld <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bias_ram_loader.sv
// Bias RAM write side: unpacks DMA stream words into bias entries.
// Optional feature macro: BIAS_LOAD_CHKSUM_EN adds o_chksum.
module bias_ram_loader
    import bias_ram_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int BIAS_WIDTH = DEF_BIAS_WIDTH,
    parameter int IN_WIDTH   = DEF_IN_WIDTH
)(
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_load_start,
    input  logic [ADDR_WIDTH-1:0] i_addr_start_b,
    input  logic [7:0]            i_output_layers,
    input  logic [IN_WIDTH-1:0]   i_s_data,
    input  logic                  i_s_valid,
    output logic                  o_s_ready,
    output logic                  o_ram_wr_en,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [BIAS_WIDTH-1:0] o_ram_wr_dat,
    output logic                  o_busy,
    output logic                  o_load_done
`ifdef BIAS_LOAD_CHKSUM_EN
    ,
    output logic [15:0]           o_chksum
`endif
);

    localparam int LANES = lanes_of(IN_WIDTH, BIAS_WIDTH);

    logic [1:0]            r_state;
    logic [7:0]            r_words_left;
    logic [7:0]            r_entries_left;
    logic [ADDR_WIDTH-1:0] r_next_addr;
    logic                  r_wr_en;
    logic [ADDR_WIDTH-1:0] r_ram_addr;
    logic [BIAS_WIDTH-1:0] r_wr_dat;

    logic                  w_start;
    logic                  w_load;
    logic                  w_ready;
    logic                  w_xfer;
    logic                  w_wr;
    logic                  w_drop;
    logic                  w_hold_vld;
    logic                  w_hold_last;
    logic                  w_src_vld;
    logic [BIAS_WIDTH-1:0] w_src_dat;

    assign w_start = i_load_start && (r_state == ST_IDLE);
    assign w_load  = (r_state == ST_LOAD);
    assign w_ready = w_load && (r_words_left != 8'd0)
                     && (!w_hold_vld || w_hold_last);
    assign w_xfer  = w_ready && i_s_valid;
    assign w_wr    = w_load && w_src_vld;
    assign w_drop  = w_wr && (r_entries_left == 8'd1);

    assign o_s_ready    = w_ready;
    assign o_ram_wr_en  = r_wr_en;
    assign o_ram_addr   = r_ram_addr;
    assign o_ram_wr_dat = r_wr_dat;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_load_done  = (r_state == ST_DONE);

    bias_lane_unpack #(
        .BIAS_WIDTH (BIAS_WIDTH),
        .IN_WIDTH   (IN_WIDTH)
    ) u_unpack (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_start),
        .i_xfer      (w_xfer),
        .i_take      (w_wr),
        .i_drop      (w_drop),
        .i_data      (i_s_data),
        .o_hold_vld  (w_hold_vld),
        .o_hold_last (w_hold_last),
        .o_src_vld   (w_src_vld),
        .o_src_dat   (w_src_dat)
    );

    // load sequencing; LOAD ends once every entry is written
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state <= (i_output_layers != 8'd0) ?
                                   ST_LOAD : ST_DONE;
                    end
                end
                ST_LOAD: begin
                    if (r_entries_left == 8'd0) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // word / entry counters and next write address
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_words_left   <= '0;
            r_entries_left <= '0;
            r_next_addr    <= '0;
        end else if (w_start) begin
            r_words_left   <= words_for(i_output_layers, LANES);
            r_entries_left <= i_output_layers;
            r_next_addr    <= i_addr_start_b;
        end else begin
            if (w_xfer) begin
                r_words_left <= r_words_left - 8'd1;
            end
            if (w_wr) begin
                r_entries_left <= r_entries_left - 8'd1;
                r_next_addr    <= r_next_addr + ADDR_WIDTH'(1);
            end
        end
    end

    // registered RAM port; address/data hold between writes
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_en    <= 1'b0;
            r_ram_addr <= '0;
            r_wr_dat   <= '0;
        end else begin
            r_wr_en <= w_wr;
            if (w_wr) begin
                r_ram_addr <= r_next_addr;
                r_wr_dat   <= w_src_dat;
            end
        end
    end

`ifdef BIAS_LOAD_CHKSUM_EN
    logic [15:0] r_chksum;

    assign o_chksum = r_chksum;

    // wrapping sum of every written entry, cleared on start
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_chksum <= '0;
        end else if (w_start) begin
            r_chksum <= '0;
        end else if (w_wr) begin
            r_chksum <= r_chksum + 16'(w_src_dat);
        end
    end
`endif

endmodule

// File: tb/tb_bias_ram_loader.sv
// Directed bench for bias_ram_loader with a write-list model.
// Build with BIAS_LOAD_CHKSUM_EN to also check o_chksum.
module tb_bias_ram_loader;

    typedef struct {
        logic [7:0]  a;
        logic [15:0] d;
    } wr_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [7:0]  addr;
    logic [7:0]  lay;
    logic [31:0] data;
    logic        valid;
    logic        ready;
    logic        wr_en;
    logic [7:0]  ram_addr;
    logic [15:0] wr_dat;
    logic        busy;
    logic        done;
`ifdef BIAS_LOAD_CHKSUM_EN
    logic [15:0] chksum;
`endif

    bias_ram_loader dut (
        .i_clk           (clk),
        .i_rst_n         (rst_n),
        .i_load_start    (start),
        .i_addr_start_b  (addr),
        .i_output_layers (lay),
        .i_s_data        (data),
        .i_s_valid       (valid),
        .o_s_ready       (ready),
        .o_ram_wr_en     (wr_en),
        .o_ram_addr      (ram_addr),
        .o_ram_wr_dat    (wr_dat),
        .o_busy          (busy),
        .o_load_done     (done)
`ifdef BIAS_LOAD_CHKSUM_EN
        ,
        .o_chksum        (chksum)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_cnt = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          last_wr_cyc = 0;
    int          first_wr_cyc = 0;
    bit          want_first = 0;
    wr_t         exp_q[$];
    logic [15:0] ram [256];
    logic [31:0] w_arr [4];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // every write is matched against the model's write list
    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en) begin
                wr_t e;
                wr_cnt++;
                last_wr_cyc = cyc;
                ram[ram_addr] = wr_dat;
                if (want_first) begin
                    first_wr_cyc = cyc;
                    want_first = 0;
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr %0h dat %0h",
                             ram_addr, wr_dat);
                end else begin
                    e = exp_q.pop_front();
                    if (ram_addr !== e.a || wr_dat !== e.d) begin
                        errors++;
                        $display("FAIL write: got %0h:%0h expected %0h:%0h",
                                 ram_addr, wr_dat, e.a, e.d);
                    end
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic outputs_zero(input string nm);
        chk({nm, "_wr_en"}, 32'(wr_en), 0);
        chk({nm, "_addr"}, 32'(ram_addr), 0);
        chk({nm, "_dat"}, 32'(wr_dat), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
        chk({nm, "_done"}, 32'(done), 0);
        chk({nm, "_ready"}, 32'(ready), 0);
    endtask

    task automatic do_load(input logic [7:0] base, input logic [7:0] layers,
                           input int nw, input bit stall,
                           input bit restart, input int abort_after);
        int          idx;
        int          wr0;
        int          dn0;
        int          sc;
        int          acc_cyc;
        bit          fin;
        bit          aborted;
        logic [15:0] sum;
        wr_t         e;
        idx = 0;
        fin = 0;
        aborted = 0;
        sum = '0;
        acc_cyc = -1;
        for (int i = 0; i < int'(layers); i++) begin
            e.a = base + 8'(i);
            e.d = 16'(w_arr[i/2] >> (16 * (i % 2)));
            exp_q.push_back(e);
            sum = sum + e.d;
        end
        wr0 = wr_cnt;
        dn0 = done_cnt;
        want_first = 1;
        @(posedge clk); #1;
        start = 1'b1;
        addr = base;
        lay = layers;
        valid = 1'b0;
        @(negedge clk); #1;
        sc = cyc;
        @(posedge clk); #1;
        for (int k = 0; k < 60 && !fin; k++) begin
            start = restart && (k == 2);
            addr = start ? 8'h80 : 8'h55;
            lay = start ? 8'h00 : 8'h77;
            if (idx < nw) begin
                valid = !(stall && (k == 1 || k == 2));
                data = w_arr[idx];
            end else begin
                valid = 1'b1;
                data = 32'hDEADBEEF;
            end
            @(negedge clk); #1;
            if (k == 0) chk("busy_on", 32'(busy), 1);
            if (idx >= nw) begin
                chk("ready_low_after_last_word", 32'(ready), 0);
            end else if (valid && ready) begin
                if (idx == 0) acc_cyc = cyc;
                idx++;
            end
            if (abort_after > 0 && wr_cnt - wr0 == abort_after) begin
                rst_n = 1'b0;
                aborted = 1;
                fin = 1;
            end else if (done_cnt != dn0) begin
                fin = 1;
            end else begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        valid = 1'b0;
        chk("load_finished_in_budget", 32'(fin), 1);
        if (aborted) begin
            #1;
            outputs_zero("abort");
            exp_q.delete();
            repeat (2) @(posedge clk);
            #1 rst_n = 1'b1;
            repeat (4) @(negedge clk);
            #1;
            chk("no_done_after_abort", 32'(done_cnt), 32'(dn0));
            chk("abort_writes", 32'(wr_cnt - wr0), 32'(abort_after));
        end else begin
            chk("all_writes_seen", 32'(exp_q.size()), 0);
            chk("write_count", 32'(wr_cnt - wr0), 32'(layers));
            chk("words_accepted", 32'(idx), 32'(nw));
            if (layers == 8'd0) begin
                chk("done_latency_empty", 32'(done_cyc), 32'(sc + 1));
            end else begin
                chk("done_after_last_write", 32'(done_cyc),
                    32'(last_wr_cyc + 1));
                chk("first_write_latency", 32'(first_wr_cyc),
                    32'(acc_cyc + 1));
            end
`ifdef BIAS_LOAD_CHKSUM_EN
            chk("chksum", 32'(chksum), 32'(sum));
`endif
            @(negedge clk); #1;
            chk("busy_off", 32'(busy), 0);
            chk("done_one_cycle", 32'(done), 0);
            chk("single_done", 32'(done_cnt), 32'(dn0 + 1));
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        addr = '0;
        lay = '0;
        data = '0;
        valid = 1'b0;
        for (int i = 0; i < 256; i++) ram[i] = '0;
        repeat (2) @(negedge clk);
        #1;
        outputs_zero("reset");
        @(posedge clk); #1 rst_n = 1'b1;

        // case 1: four entries, back-to-back words
        w_arr[0] = 32'h00020001;
        w_arr[1] = 32'h00040003;
        do_load(8'h10, 8'd4, 2, 0, 0, 0);
        chk("t1_last_addr", 32'(ram_addr), 32'h13);
        chk("t1_last_dat", 32'(wr_dat), 32'h0004);
        chk("t1_consecutive", 32'(last_wr_cyc - first_wr_cyc), 3);
`ifdef BIAS_LOAD_CHKSUM_EN
        chk("t1_chksum_literal", 32'(chksum), 32'h000A);
`endif

        // case 2: odd tail, upper lane of word 2 dropped
        do_load(8'h10, 8'd3, 2, 0, 0, 0);
        chk("t2_last_addr", 32'(ram_addr), 32'h12);
        chk("t2_last_dat", 32'(wr_dat), 32'h0003);

        // case 3: address wrap
        w_arr[0] = 32'h00BB00AA;
        w_arr[1] = 32'h00DD00CC;
        do_load(8'hFE, 8'd4, 2, 0, 0, 0);
        chk("t3_last_addr", 32'(ram_addr), 32'h01);
        chk("t3_last_dat", 32'(wr_dat), 32'h00DD);
        chk("t3_ram_ff", 32'(ram[8'hFF]), 32'h00BB);

        // case 4: stream stall mid-load
        w_arr[0] = 32'h00020001;
        w_arr[1] = 32'h00040003;
        for (int i = 16; i < 20; i++) ram[i] = '0;
        do_load(8'h10, 8'd4, 2, 1, 0, 0);
        chk("t4_span", 32'(last_wr_cyc - first_wr_cyc), 4);
        chk("t4_ram10", 32'(ram[8'h10]), 32'h0001);
        chk("t4_ram11", 32'(ram[8'h11]), 32'h0002);
        chk("t4_ram12", 32'(ram[8'h12]), 32'h0003);
        chk("t4_ram13", 32'(ram[8'h13]), 32'h0004);

        // case 5: empty load, then a start during busy
        do_load(8'h40, 8'd0, 0, 0, 0, 0);
        do_load(8'h30, 8'd4, 2, 0, 1, 0);
        chk("t5_last_addr", 32'(ram_addr), 32'h33);

        // case 6: reset after two writes, then a clean load
        do_load(8'h20, 8'd4, 2, 0, 0, 2);
        do_load(8'h10, 8'd4, 2, 0, 0, 0);
        chk("t6_last_addr", 32'(ram_addr), 32'h13);
        chk("t6_last_dat", 32'(wr_dat), 32'h0004);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
